// File: rtl/m_varredura.sv
// Scan controller for the 4:1 mux stage: latches a word, steps the mux select
// through all four values, samples y back and flags any mismatch.
module m_varredura #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dado_in,
  input  logic       msb_first,
  input  logic       mux_y,
  output logic [3:0] mux_d,
  output logic [1:0] mux_s,
  output logic       busy,
  output logic       done,
  output logic [3:0] palavra_out,
  output logic       erro
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [3:0] mux_d_q, mux_d_d;
  logic [1:0] mux_s_q, mux_s_d;
  logic       desc_q, desc_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] palavra_q, palavra_d;
  logic       erro_q, erro_d;
  logic [3:0] sampled;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mux_d_d   = mux_d_q;
    mux_s_d   = mux_s_q;
    desc_d    = desc_q;
    dwell_d   = dwell_q;
    bit_d     = bit_q;
    shadow_d  = shadow_q;
    palavra_d = palavra_q;
    erro_d    = erro_q;
    sampled   = shadow_q;
    sampled[mux_s_q] = mux_y;

    case (state_q)
      IDLE: begin
        if (start) begin
          mux_d_d   = dado_in;
          desc_d    = msb_first;
          mux_s_d   = msb_first ? 2'd3 : 2'd0;
          dwell_d   = 8'd0;
          bit_d     = 3'd0;
          shadow_d  = 4'd0;
          palavra_d = 4'd0;
          erro_d    = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        dwell_d = dwell_q + 8'd1;
        if (dwell_q == DWELL_LAST) begin
          // y is combinational from mux_d/mux_s, so it is valid in this cycle
          shadow_d = sampled;
          dwell_d  = 8'd0;
          bit_d    = bit_q + 3'd1;
          mux_s_d  = desc_q ? mux_s_q - 2'd1 : mux_s_q + 2'd1;
          if (bit_q == 3'd3) begin
            palavra_d = sampled;
            erro_d    = (sampled != mux_d_q);
            mux_s_d   = desc_q ? 2'd3 : 2'd0;
            state_d   = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mux_d_q   <= 4'd0;
      mux_s_q   <= 2'd0;
      desc_q    <= 1'b0;
      dwell_q   <= 8'd0;
      bit_q     <= 3'd0;
      shadow_q  <= 4'd0;
      palavra_q <= 4'd0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mux_d_q   <= mux_d_d;
      mux_s_q   <= mux_s_d;
      desc_q    <= desc_d;
      dwell_q   <= dwell_d;
      bit_q     <= bit_d;
      shadow_q  <= shadow_d;
      palavra_q <= palavra_d;
      erro_q    <= erro_d;
    end
  end

  assign mux_d       = mux_d_q;
  assign mux_s       = mux_s_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign palavra_out = palavra_q;
  assign erro        = erro_q;

endmodule

// File: tb/tb_m_varredura.sv
// Directed bench for m_varredura with a behavioural 4:1 mux closing the loop
// and a fault switch that forces the mux output low.
module tb_m_varredura;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dado_in;
  logic       msb_first;
  logic       mux_y;
  logic [3:0] mux_d;
  logic [1:0] mux_s;
  logic       busy;
  logic       done;
  logic [3:0] palavra_out;
  logic       erro;
  logic       fault;

  int tests = 0;
  int fails = 0;

  m_varredura #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dado_in     (dado_in),
    .msb_first   (msb_first),
    .mux_y       (mux_y),
    .mux_d       (mux_d),
    .mux_s       (mux_s),
    .busy        (busy),
    .done        (done),
    .palavra_out (palavra_out),
    .erro        (erro)
  );

  assign mux_y = fault ? 1'b0 : mux_d[mux_s];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mux_d"}, 8'(mux_d), 8'h0);
    check({tag, ".mux_s"}, 8'(mux_s), 8'h0);
    check({tag, ".busy"}, 8'(busy), 8'h0);
    check({tag, ".done"}, 8'(done), 8'h0);
    check({tag, ".palavra"}, 8'(palavra_out), 8'h0);
    check({tag, ".erro"}, 8'(erro), 8'h0);
  endtask

  // Full scan starting now; ends in the first IDLE cycle after DONE.
  task automatic do_scan(input logic [3:0] d, input logic msb, input logic [3:0] exp_word,
                         input logic exp_err, input bit spurious);
    logic [1:0] exp_s;
    start = 1'b1; dado_in = d; msb_first = msb;
    step();  // edge E
    start = 1'b0;
    for (int k = 0; k < 4 * DWELL; k++) begin
      exp_s = msb ? 2'(3 - k / DWELL) : 2'(k / DWELL);
      check("scan.mux_s", 8'(mux_s), 8'(exp_s));
      check("scan.mux_d", 8'(mux_d), 8'(d));
      check("scan.busy", 8'(busy), 8'h1);
      check("scan.done", 8'(done), 8'h0);
      if (spurious && k == 5) begin start = 1'b1; dado_in = ~d; msb_first = ~msb; end
      if (spurious && k == 6) start = 1'b0;
      step();
    end
    check("done.done", 8'(done), 8'h1);
    check("done.busy", 8'(busy), 8'h1);
    check("done.palavra", 8'(palavra_out), 8'(exp_word));
    check("done.erro", 8'(erro), 8'(exp_err));
    check("done.mux_s", 8'(mux_s), msb ? 8'h3 : 8'h0);
    step();
    check("idle.done", 8'(done), 8'h0);
    check("idle.busy", 8'(busy), 8'h0);
    check("idle.palavra", 8'(palavra_out), 8'(exp_word));
    check("idle.erro", 8'(erro), 8'(exp_err));
    check("idle.mux_d", 8'(mux_d), 8'(d));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dado_in = 4'h0; msb_first = 1'b0; fault = 1'b0;
    step();
    step();
    check_all_zero("reset");

    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_all_zero("idle10");

    do_scan(4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0);
    do_scan(4'b1100, 1'b1, 4'b1100, 1'b0, 1'b0);

    fault = 1'b1;
    do_scan(4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0);
    fault = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("fault_hold.palavra", 8'(palavra_out), 8'h0);
    check("fault_hold.erro", 8'(erro), 8'h1);

    // Ignored start mid-scan, then a start in the first IDLE cycle after DONE
    do_scan(4'b0110, 1'b0, 4'b0110, 1'b0, 1'b1);
    do_scan(4'b1001, 1'b1, 4'b1001, 1'b0, 1'b0);

    // Reset at the edge of sample 2 (E+2*DWELL)
    start = 1'b1; dado_in = 4'b0111; msb_first = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 2 * DWELL - 1; i++) step();
    check("pre_rst.busy", 8'(busy), 8'h1);
    rst_n = 1'b0;
    step();
    check_all_zero("mid_rst");
    rst_n = 1'b1;
    step();
    check("post_rst.done", 8'(done), 8'h0);
    check("post_rst.busy", 8'(busy), 8'h0);
    do_scan(4'b1010, 1'b0, 4'b1010, 1'b0, 1'b0);

    // Reset wins over start at the same edge
    rst_n = 1'b0; start = 1'b1; dado_in = 4'hF;
    step();
    check_all_zero("rst_prio");
    rst_n = 1'b1; start = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
